// File: rtl/udp_rx_pkt_ctrl.sv
// udp_rx_pkt_ctrl: buffers UDP payload words, commits whole datagrams on rec_end,
// and presents them to one consumer as a length descriptor plus a pull-mode word stream.
module udp_rx_pkt_ctrl #(
    parameter int ADDR_W   = 9,
    parameter int MAX_PKTS = 4
) (
    input  logic        eth_rx_clk,
    input  logic        sys_rst_n,
    input  logic        rec_data_en,
    input  logic [31:0] rec_data,
    input  logic        rec_end,
    input  logic [15:0] rec_data_num,
    output logic        pkt_valid,
    output logic [15:0] pkt_len,
    input  logic        pkt_ready,
    input  logic        rd_en,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic [15:0] drop_cnt,
    output logic        drop_pulse
);
    localparam int PW = $clog2(MAX_PKTS);
    localparam logic [ADDR_W:0] DEPTH_W = ADDR_W'(0) | (1 << ADDR_W);
    localparam logic [ADDR_W:0] ONE = 1;
    localparam logic [PW:0] MAXP = MAX_PKTS;

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_HEAD, R_STREAM} r_state_t;

    w_state_t w_q, w_d;
    r_state_t r_q, r_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, start_q, start_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d, rem_q, rem_d;
    logic [PW:0] fw_q, fw_d, fr_q, fr_d;
    logic [15:0] pkt_len_q, pkt_len_d, drop_cnt_q, drop_cnt_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, drop_pulse_q, drop_pulse_d;
    logic [31:0] ram [2**ADDR_W];
    logic [ADDR_W:0] desc_start [MAX_PKTS];
    logic [15:0] desc_len [MAX_PKTS];
    logic wr_en, push, pop, drop, ram_full, fifo_full, fifo_empty, dropping, ending, issue;
    logic [ADDR_W:0] used, acc, first;
    logic [16:0] need;

    always_ff @(posedge eth_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            w_q          <= W_IDLE;
            r_q          <= R_IDLE;
            wr_ptr_q     <= '0;
            cm_ptr_q     <= '0;
            start_q      <= '0;
            rd_ptr_q     <= '0;
            rem_q        <= '0;
            fw_q         <= '0;
            fr_q         <= '0;
            pkt_len_q    <= '0;
            drop_cnt_q   <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            w_q          <= w_d;
            r_q          <= r_d;
            wr_ptr_q     <= wr_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            start_q      <= start_d;
            rd_ptr_q     <= rd_ptr_d;
            rem_q        <= rem_d;
            fw_q         <= fw_d;
            fr_q         <= fr_d;
            pkt_len_q    <= pkt_len_d;
            drop_cnt_q   <= drop_cnt_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    // Storage has no reset: contents are meaningless once the pointers clear.
    always_ff @(posedge eth_rx_clk) begin
        if (wr_en) ram[wr_ptr_q[ADDR_W-1:0]] <= rec_data;
        if (push) begin
            desc_start[fw_q[PW-1:0]] <= first;
            desc_len[fw_q[PW-1:0]]   <= rec_data_num;
        end
    end

    always_comb begin
        used       = wr_ptr_q - rd_ptr_q;
        ram_full   = used == DEPTH_W;
        fifo_full  = (fw_q - fr_q) == MAXP;
        fifo_empty = fw_q == fr_q;
        w_d        = w_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        start_d    = start_q;
        first      = (w_q == W_IDLE) ? cm_ptr_q : start_q;
        dropping   = (w_q == W_DROP) || (rec_data_en && (ram_full || (w_q == W_IDLE && fifo_full)));
        wr_en      = rec_data_en && !dropping;
        if (rec_data_en) begin
            start_d = first;
            w_d     = dropping ? W_DROP : W_RECV;
        end
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        // Word count includes the word written alongside rec_end.
        acc    = wr_ptr_d - first;
        need   = ({1'b0, rec_data_num} + 17'd3) >> 2;
        ending = rec_end && (w_q != W_IDLE || rec_data_en);
        push   = ending && !dropping && acc != '0 && 17'(acc) == need;
        drop   = ending && !push;
        if (ending) w_d = W_IDLE;
        if (push) cm_ptr_d = wr_ptr_d;
        if (drop) wr_ptr_d = cm_ptr_q;
        drop_pulse_d = drop;
        drop_cnt_d   = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        r_d       = r_q;
        rd_ptr_d  = rd_ptr_q;
        rem_d     = rem_q;
        pkt_len_d = pkt_len_q;
        issue     = 1'b0;
        pop       = 1'b0;
        case (r_q)
            R_IDLE: if (!fifo_empty) begin
                r_d       = R_HEAD;
                pkt_len_d = desc_len[fr_q[PW-1:0]];
                rem_d     = (ADDR_W+1)'(({1'b0, desc_len[fr_q[PW-1:0]]} + 17'd3) >> 2);
                rd_ptr_d  = desc_start[fr_q[PW-1:0]];
            end
            R_HEAD: r_d = pkt_ready ? R_STREAM : R_HEAD;
            R_STREAM: begin
                issue = rd_en && rem_q != '0;
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    rem_d    = rem_q - 1'b1;
                    pop      = rem_q == ONE;
                    r_d      = pop ? R_IDLE : R_STREAM;
                end
            end
            default: r_d = R_IDLE;
        endcase
        rd_valid_d = issue;
        rd_last_d  = issue && rem_q == ONE;
        rd_data_d  = issue ? ram[rd_ptr_q[ADDR_W-1:0]] : rd_data_q;
        fw_d       = push ? fw_q + 1'b1 : fw_q;
        fr_d       = pop ? fr_q + 1'b1 : fr_q;
    end

    always_comb begin
        pkt_valid  = r_q == R_HEAD;
        pkt_len    = pkt_len_q;
        rd_valid   = rd_valid_q;
        rd_data    = rd_data_q;
        rd_last    = rd_last_q;
        drop_cnt   = drop_cnt_q;
        drop_pulse = drop_pulse_q;
    end
endmodule

// File: tb/tb_udp_rx_pkt_ctrl.sv
// tb_udp_rx_pkt_ctrl: directed and random datagrams checked against a queue-based
// model of committed packets, buffer occupancy and drop count.
module tb_udp_rx_pkt_ctrl;
    localparam int DEPTH = 16;
    localparam int MAXP  = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        rec_data_en = 1'b0, rec_end = 1'b0, pkt_ready = 1'b0, rd_en = 1'b0;
    logic [31:0] rec_data = '0;
    logic [15:0] rec_data_num = '0;
    logic        pkt_valid, rd_valid, rd_last, drop_pulse;
    logic [15:0] pkt_len, drop_cnt;
    logic [31:0] rd_data;

    int tests = 0, fails = 0, exp_drops = 0;
    int qlen[$];
    logic [31:0] qwords[$];
    logic [31:0] wbuf[$];

    udp_rx_pkt_ctrl #(.ADDR_W(4), .MAX_PKTS(MAXP)) dut (
        .eth_rx_clk(clk), .sys_rst_n(rst_n), .rec_data_en(rec_data_en), .rec_data(rec_data),
        .rec_end(rec_end), .rec_data_num(rec_data_num), .pkt_valid(pkt_valid), .pkt_len(pkt_len),
        .pkt_ready(pkt_ready), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n);
        wbuf = {};
        for (int i = 0; i < n; i++) wbuf.push_back($urandom);
    endtask

    // A datagram commits only if a descriptor slot is free, all words fit, and the byte count matches.
    task automatic send(input int num, input bit lat);
        int n = wbuf.size();
        bit ok;
        ok = n >= 1 && qlen.size() < MAXP && qwords.size() + n <= DEPTH && n == (num + 3) / 4;
        if (ok) begin
            qlen.push_back(num);
            foreach (wbuf[i]) qwords.push_back(wbuf[i]);
        end else exp_drops++;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rec_data_en  = 1'b1;
            rec_data     = wbuf[i];
            rec_end      = (i == n - 1);
            rec_data_num = 16'(num);
        end
        @(negedge clk);
        rec_data_en = 1'b0;
        rec_end     = 1'b0;
        chk("drop_pulse", drop_pulse, !ok);
        chk("drop_cnt", drop_cnt, exp_drops);
        if (lat) chk("pkt_valid_T1", pkt_valid, 0);
        @(negedge clk);
        chk("drop_pulse_low", drop_pulse, 0);
        if (lat) chk("pkt_valid_T2", pkt_valid, 1);
    endtask

    task automatic read_pkt(input bit gaps, input int stop);
        int w = 0;
        int len, n;
        while (pkt_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("pkt_valid_wait", pkt_valid, 1);
        len = qlen[0];
        n   = (len + 3) / 4;
        chk("pkt_len", pkt_len, len);
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        chk("pkt_valid_fall", pkt_valid, 0);
        for (int i = 0; i < n; i++) begin
            if (i == stop) return;
            if (gaps && $urandom_range(0, 3) == 0) begin
                rd_en = 1'b0;
                @(negedge clk);
                chk("rd_valid_gap", rd_valid, 0);
            end
            rd_en = 1'b1;
            @(negedge clk);
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, qwords.pop_front());
            chk("rd_last", rd_last, i == n - 1);
        end
        @(negedge clk);
        chk("rd_valid_extra", rd_valid, 0);
        rd_en = 1'b0;
        void'(qlen.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_pkt_len", pkt_len, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_drop_pulse", drop_pulse, 0);
        rec_data_en = 1'b0;
        rec_end     = 1'b0;
        pkt_ready   = 1'b0;
        rd_en       = 1'b0;
        qlen        = {};
        qwords      = {};
        exp_drops   = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        wbuf = {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11120000};
        send(18, 1'b1);
        read_pkt(1'b0, -1);
        chk("pkt_valid_after_read", pkt_valid, 0);

        fill(2); send(8, 1'b0);
        fill(1); send(4, 1'b0);
        fill(3); send(12, 1'b0);
        repeat (3) read_pkt(1'b1, -1);
        chk("drop_cnt_b2b", drop_cnt, 0);

        do_reset();
        fill(10); send(40, 1'b0);
        fill(12); send(48, 1'b0);
        chk("drop_cnt_overflow", drop_cnt, 1);
        read_pkt(1'b0, -1);
        fill(4); send(16, 1'b0);
        read_pkt(1'b0, -1);

        do_reset();
        repeat (5) begin fill(1); send(4, 1'b0); end
        chk("drop_cnt_fifo_full", drop_cnt, 1);
        read_pkt(1'b0, -1);
        fill(1); send(4, 1'b0);
        chk("drop_cnt_after_free", drop_cnt, 1);
        while (qlen.size() > 0) read_pkt(1'b1, -1);

        do_reset();
        fill(2); send(10, 1'b0);
        repeat (3) @(negedge clk);
        chk("pkt_valid_len_mismatch", pkt_valid, 0);
        chk("drop_cnt_len_mismatch", drop_cnt, 1);

        do_reset();
        fill(4); send(16, 1'b0);
        read_pkt(1'b0, 2);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rec_data_en = 1'b1;
            rec_data    = $urandom;
        end
        do_reset();
        fill(3); send(12, 1'b0);
        read_pkt(1'b0, -1);

        do_reset();
        repeat (40) begin
            int n, num;
            n   = $urandom_range(1, 7);
            num = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 30)) : 4 * n - int'($urandom_range(0, 3));
            fill(n);
            send(num, 1'b0);
            if (qlen.size() > 0 && $urandom_range(0, 1) == 1) read_pkt(1'b1, -1);
        end
        while (qlen.size() > 0) read_pkt(1'b1, -1);
        chk("drop_cnt_random", drop_cnt, exp_drops);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
